adc_ad7608_emulator: RTL and testbench
======================================

// Module: adc_ad7608_emulator
// PURPOSE
//  Synthesizable AD7608 responder: the device end of the ADC serial interface the adc_controller drives.
//  Accepts CONVST/RESET/OS/SCLK/nCS, drives BUSY and 18-bit two-lane serial data from host-written sample
//  registers or an internal ramp. Enables on-board ADC->PID->DAC loopback without the physical converter.
// PARAMETERS
//  W_DATA  18   sample width (bits per channel frame)
//  N_CHAN  8    channels; lane A = ch0..3, lane B = ch4..7
//  W_CHAN  3    channel index width
//  W_OS    3    oversample field width
//  T_CONV  200  base conversion time, clk_in cycles (os=0)
//  W_CNT   16   conversion counter width
// PORTS
//  clk_in        in   1       system clock; sclk_in is >=4x slower
//  n_rst_in      in   1       asynchronous active-low reset
//  convst_in     in   1       conversion start; rising edge starts a conversion
//  reset_in      in   1       device RESET pin, active high, abort
//  os_in         in   W_OS    oversample ratio select
//  sclk_in       in   1       serial clock; data advances on falling edge
//  n_cs_in       in   1       chip select, active low
//  busy_out      out  1       high while converting
//  data_a_out    out  1       serial lane A, MSB first
//  data_b_out    out  1       serial lane B, MSB first
//  wr_en_in      in   1       sample-register write strobe (1 cycle)
//  wr_chan_in    in   W_CHAN  sample-register index
//  wr_data_in    in   W_DATA  sample value (two's complement)
//  ramp_en_in    in   1       1: snapshot ramp pattern instead of registers
//  conv_cnt_out  out  W_CNT   completed conversions, wraps
//  overrun_out   out  1       sticky: CONVST rose while busy; cleared by reset_in
// BEHAVIOUR
//  - n_rst_in low: all state 0; busy/data/overrun/conv_cnt outputs 0, FSM IDLE, sample regs 0.
//  - convst_in, reset_in, sclk_in, n_cs_in pass a 2-flop synchronizer; edges detected on synced copies.
//  - FSM IDLE/CONV. IDLE: convst rise -> CONV; busy_out registered high 3 clk after convst_in rises.
//  - CONV lasts T_CONV<<os_in cycles (os_in latched at start; os>=7 treated as 0); then busy low, -> IDLE.
//  - Same cycle busy falls: shadow[i] <= ramp_en ? (conv_cnt+i) mod 2^W_DATA : sample[i]; conv_cnt++.
//  - convst rise while CONV: ignored, overrun_out <= 1.
//  - Readout independent of FSM: synced n_cs fall loads lane shifters with shadow[0]/shadow[4]; MSB on
//    outputs next cycle. Each synced sclk fall shifts 1 bit; after W_DATA bits next channel (1->2->3 / 5->6->7).
//    After 4*W_DATA bits outputs hold 0. n_cs high: outputs 0, bit counter cleared.
//  - Conversion during readout: shadow update does not disturb active shifters; next n_cs fall sees new data.
//  - wr_en same cycle as snapshot: snapshot takes old value; write lands for next conversion.
//  - reset_in high (synced): busy 0, FSM IDLE, shadow 0, shifters cleared, overrun 0; sample regs, conv_cnt kept.
//  - convst rise while reset_in high: ignored, no overrun.
// STRUCTURE
//  - W_ADC_DATA/W_ADC_CHAN/N_ADC/W_ADC_OS from parameters.vh; FSM state encodings localparams.
//  - One sub-module: ad7608_lane_shifter (one per lane; 4 x W_DATA frame load, shift, bit/channel counters).
//  - Top: synchronizers, edge detect, conversion FSM/timer, sample+shadow regs, ramp, counters.
// TESTING
//  1. Write ch0=0x2AAAA, ch4=0x15555, convst pulse, os=0 -> busy rises +3 clk, high 200 clk; nCS low,
//     72 sclk -> lane A first 18 bits 0x2AAAA, lane B 0x15555; conv_cnt=1.
//  2. os_in=2 -> busy exactly 800 clk; os_in=7 -> 200 clk.
//  3. ramp_en=1, three conversions -> third readout lane A ch0..3 = 2,3,4,5; lane B ch4..7 = 6,7,8,9.
//  4. Second convst 50 clk into conversion -> busy still 200 clk total, overrun_out=1, conv_cnt +1 only.
//  5. Readout of conversion N while conversion N+1 completes -> all 72 bits are N data; next frame is N+1.
//  6. reset_in mid-conversion and n_rst_in mid-readout -> busy 0 within 3 clk, outputs 0, overrun cleared.

Source files
------------

// File: rtl/adc_ad7608_emulator_pkg.sv
// rtl/adc_ad7608_emulator_pkg.sv - shared widths, FSM encoding and conversion-time helper for the AD7608 emulator
package adc_ad7608_emulator_pkg;

    localparam int W_ADC_DATA = 18;
    localparam int N_ADC      = 8;
    localparam int W_ADC_CHAN = 3;
    localparam int W_ADC_OS   = 3;
    localparam int T_ADC_CONV = 200;
    localparam int W_ADC_CNT  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    // Oversample code 7 is reserved on the real part; it behaves like no oversampling.
    function automatic int conv_len(input int t_conv, input int os);
        return (os >= 7) ? t_conv : (t_conv << os);
    endfunction

endpackage

// File: rtl/ad7608_lane_shifter.sv
// rtl/ad7608_lane_shifter.sv - one serial lane: loads a multi-channel frame and shifts it out MSB first
module ad7608_lane_shifter
    import adc_ad7608_emulator_pkg::*;
#(
    parameter int W_DATA  = W_ADC_DATA,
    parameter int N_FRAME = N_ADC / 2
) (
    input  logic                        clk_in,
    input  logic                        n_rst_in,
    input  logic                        clear_in,
    input  logic                        cs_active_in,
    input  logic                        load_in,
    input  logic                        shift_in,
    input  logic [N_FRAME*W_DATA-1:0]   frame_in,
    output logic                        data_out
);

    localparam int W_BIT = $clog2(W_DATA);
    localparam int W_CH  = $clog2(N_FRAME + 1);

    logic [N_FRAME*W_DATA-1:0] r_frame;
    logic [W_BIT-1:0]          r_bit_cnt;
    logic [W_CH-1:0]           r_chan_cnt;
    logic                      r_active;
    logic                      w_done;

    assign w_done = (r_chan_cnt == W_CH'(N_FRAME));

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_chan_cnt <= '0;
            r_active   <= 1'b0;
        end else if (clear_in || !cs_active_in) begin
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_chan_cnt <= '0;
            r_active   <= 1'b0;
        end else if (load_in) begin
            r_frame    <= frame_in;
            r_bit_cnt  <= '0;
            r_chan_cnt <= '0;
            r_active   <= 1'b1;
        end else if (shift_in && r_active && !w_done) begin
            r_frame <= r_frame << 1;
            if (r_bit_cnt == W_BIT'(W_DATA - 1)) begin
                r_bit_cnt  <= '0;
                r_chan_cnt <= r_chan_cnt + W_CH'(1);
            end else begin
                r_bit_cnt <= r_bit_cnt + W_BIT'(1);
            end
        end
    end

    // Once every channel has been clocked out the lane idles low until chip select is released.
    assign data_out = (r_active && !w_done) ? r_frame[N_FRAME*W_DATA-1] : 1'b0;

endmodule

// File: rtl/adc_ad7608_emulator.sv
// rtl/adc_ad7608_emulator.sv - AD7608 device-side emulator: conversion timing, sample/shadow registers, two-lane readout
module adc_ad7608_emulator
    import adc_ad7608_emulator_pkg::*;
#(
    parameter int W_DATA = W_ADC_DATA,
    parameter int N_CHAN = N_ADC,
    parameter int W_CHAN = W_ADC_CHAN,
    parameter int W_OS   = W_ADC_OS,
    parameter int T_CONV = T_ADC_CONV,
    parameter int W_CNT  = W_ADC_CNT
) (
    input  logic              clk_in,
    input  logic              n_rst_in,
    input  logic              convst_in,
    input  logic              reset_in,
    input  logic [W_OS-1:0]   os_in,
    input  logic              sclk_in,
    input  logic              n_cs_in,
    output logic              busy_out,
    output logic              data_a_out,
    output logic              data_b_out,
    input  logic              wr_en_in,
    input  logic [W_CHAN-1:0] wr_chan_in,
    input  logic [W_DATA-1:0] wr_data_in,
    input  logic              ramp_en_in,
    output logic [W_CNT-1:0]  conv_cnt_out,
    output logic              overrun_out
);

    localparam int N_HALF = N_CHAN / 2;

    // Bits [1:0] form the synchronizer; bit 2 is the previous synced value for edge detection.
    logic [2:0] r_convst_sync;
    logic [2:0] r_reset_sync;
    logic [2:0] r_sclk_sync;
    logic [2:0] r_ncs_sync;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_convst_sync <= '0;
            r_reset_sync  <= '0;
            r_sclk_sync   <= '0;
            r_ncs_sync    <= '0;
        end else begin
            r_convst_sync <= {r_convst_sync[1:0], convst_in};
            r_reset_sync  <= {r_reset_sync[1:0], reset_in};
            r_sclk_sync   <= {r_sclk_sync[1:0], sclk_in};
            r_ncs_sync    <= {r_ncs_sync[1:0], n_cs_in};
        end
    end

    logic w_convst_rise;
    logic w_reset;
    logic w_sclk_fall;
    logic w_ncs;
    logic w_ncs_fall;

    assign w_convst_rise = r_convst_sync[1] & ~r_convst_sync[2];
    assign w_reset       = r_reset_sync[1];
    assign w_sclk_fall   = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_ncs         = r_ncs_sync[1];
    assign w_ncs_fall    = ~r_ncs_sync[1] & r_ncs_sync[2];

    conv_state_t      r_state;
    conv_state_t      w_state_nxt;
    logic [W_CNT-1:0] r_timer;
    logic [W_CNT-1:0] w_conv_len;
    logic             w_start;
    logic             w_done;
    logic             w_overrun_set;
    logic             w_busy;

    assign w_conv_len = W_CNT'(conv_len(T_CONV, int'(os_in)));

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_reset) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_convst_rise) w_state_nxt = ST_CONV;
                ST_CONV: if (r_timer == '0) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_start       = 1'b0;
        w_done        = 1'b0;
        w_overrun_set = 1'b0;
        w_busy        = (r_state == ST_CONV);
        if (!w_reset) begin
            w_start       = (r_state == ST_IDLE) && w_convst_rise;
            w_done        = (r_state == ST_CONV) && (r_timer == '0);
            w_overrun_set = (r_state == ST_CONV) && w_convst_rise;
        end
    end

    // The timer is loaded at start, which is what latches the oversample ratio.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_timer <= '0;
        end else if (w_reset) begin
            r_timer <= '0;
        end else if (w_start) begin
            r_timer <= w_conv_len - W_CNT'(1);
        end else if (w_busy && r_timer != '0) begin
            r_timer <= r_timer - W_CNT'(1);
        end
    end

    logic [W_CNT-1:0] r_conv_cnt;
    logic             r_overrun;

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            r_conv_cnt <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_done) begin
                r_conv_cnt <= r_conv_cnt + W_CNT'(1);
            end
            if (w_reset) begin
                r_overrun <= 1'b0;
            end else if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    logic [W_DATA-1:0] r_sample [N_CHAN];
    logic [W_DATA-1:0] r_shadow [N_CHAN];

    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_sample[i] <= '0;
            end
        end else if (wr_en_in) begin
            r_sample[wr_chan_in] <= wr_data_in;
        end
    end

    // Snapshot reads the pre-increment count and the pre-write samples on the completing cycle.
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_reset) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_done) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_shadow[i] <= ramp_en_in ? (W_DATA'(r_conv_cnt) + W_DATA'(i)) : r_sample[i];
            end
        end
    end

    logic [N_HALF*W_DATA-1:0] w_frame_a;
    logic [N_HALF*W_DATA-1:0] w_frame_b;

    always_comb begin
        w_frame_a = '0;
        w_frame_b = '0;
        for (int i = 0; i < N_HALF; i++) begin
            w_frame_a[(N_HALF-1-i)*W_DATA +: W_DATA] = r_shadow[i];
            w_frame_b[(N_HALF-1-i)*W_DATA +: W_DATA] = r_shadow[i+N_HALF];
        end
    end

    ad7608_lane_shifter #(
        .W_DATA  (W_DATA),
        .N_FRAME (N_HALF)
    ) u_lane_a (
        .clk_in       (clk_in),
        .n_rst_in     (n_rst_in),
        .clear_in     (w_reset),
        .cs_active_in (~w_ncs),
        .load_in      (w_ncs_fall),
        .shift_in     (w_sclk_fall),
        .frame_in     (w_frame_a),
        .data_out     (data_a_out)
    );

    ad7608_lane_shifter #(
        .W_DATA  (W_DATA),
        .N_FRAME (N_HALF)
    ) u_lane_b (
        .clk_in       (clk_in),
        .n_rst_in     (n_rst_in),
        .clear_in     (w_reset),
        .cs_active_in (~w_ncs),
        .load_in      (w_ncs_fall),
        .shift_in     (w_sclk_fall),
        .frame_in     (w_frame_b),
        .data_out     (data_b_out)
    );

    assign busy_out     = w_busy;
    assign conv_cnt_out = r_conv_cnt;
    assign overrun_out  = r_overrun;

endmodule

// File: tb/tb_adc_ad7608_emulator.sv
// tb/tb_adc_ad7608_emulator.sv - scoreboard bench for the AD7608 emulator against a behavioural device model
module tb_adc_ad7608_emulator;

    localparam int WD = 18;
    localparam int TC = 200;

    logic        clk_in = 1'b0;
    logic        n_rst_in;
    logic        convst_in;
    logic        reset_in;
    logic [2:0]  os_in;
    logic        sclk_in;
    logic        n_cs_in;
    logic        busy_out;
    logic        data_a_out;
    logic        data_b_out;
    logic        wr_en_in;
    logic [2:0]  wr_chan_in;
    logic [17:0] wr_data_in;
    logic        ramp_en_in;
    logic [15:0] conv_cnt_out;
    logic        overrun_out;

    adc_ad7608_emulator dut (
        .clk_in       (clk_in),
        .n_rst_in     (n_rst_in),
        .convst_in    (convst_in),
        .reset_in     (reset_in),
        .os_in        (os_in),
        .sclk_in      (sclk_in),
        .n_cs_in      (n_cs_in),
        .busy_out     (busy_out),
        .data_a_out   (data_a_out),
        .data_b_out   (data_b_out),
        .wr_en_in     (wr_en_in),
        .wr_chan_in   (wr_chan_in),
        .wr_data_in   (wr_data_in),
        .ramp_en_in   (ramp_en_in),
        .conv_cnt_out (conv_cnt_out),
        .overrun_out  (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          start;
        int          dur;
        logic [15:0] cnt;
        logic        ovr;
    } busy_exp_t;

    typedef struct {
        logic [71:0] a;
        logic [71:0] b;
    } frame_exp_t;

    busy_exp_t  q_busy[$];
    frame_exp_t q_frame[$];

    logic [17:0] m_sample [8];
    logic [17:0] m_shadow [8];
    logic [15:0] m_cnt;
    logic        m_ovr;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sample[i] = '0;
            m_shadow[i] = '0;
        end
        m_cnt = '0;
        m_ovr = 1'b0;
    endtask

    // Busy monitor: rise latency, high time, and count/overrun when a conversion ends.
    int        mon_hi;
    logic      mon_prev;
    busy_exp_t mon_e;
    initial begin
        mon_hi   = 0;
        mon_prev = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!n_rst_in) begin
                mon_hi   = 0;
                mon_prev = 1'b0;
            end else begin
                if (busy_out && !mon_prev) begin
                    mon_hi = 0;
                    if (q_busy.size() == 0) check("busy_unexpected", 72'(1), 72'(0));
                    else check("busy_latency", 72'(cyc - q_busy[0].start), 72'(3));
                end
                if (busy_out) mon_hi++;
                if (!busy_out && mon_prev && q_busy.size() > 0) begin
                    mon_e = q_busy.pop_front();
                    check("busy_duration", 72'(mon_hi), 72'(mon_e.dur));
                    check("conv_cnt", 72'(conv_cnt_out), 72'(mon_e.cnt));
                    check("overrun", 72'(overrun_out), 72'(mon_e.ovr));
                end
                mon_prev = busy_out;
            end
        end
    end

    // Frame monitor: captures both lanes on each sclk fall while chip select is low.
    logic [71:0] cap_a;
    logic [71:0] cap_b;
    int          cap_n;
    frame_exp_t  fr_e;
    initial begin
        forever begin
            @(negedge n_cs_in);
            cap_a = '0;
            cap_b = '0;
            cap_n = 0;
            while (n_cs_in === 1'b0) begin
                @(negedge sclk_in or posedge n_cs_in);
                if (n_cs_in === 1'b0) begin
                    cap_a = {cap_a[70:0], data_a_out};
                    cap_b = {cap_b[70:0], data_b_out};
                    cap_n++;
                end
            end
            if (q_frame.size() > 0) begin
                fr_e = q_frame.pop_front();
                check("frame_lane_a", cap_a, fr_e.a);
                check("frame_lane_b", cap_b, fr_e.b);
                check("frame_bits", 72'(cap_n), 72'(72));
                check("frame_tail_zero", 72'({data_a_out, data_b_out}), 72'(0));
            end
        end
    end

    task automatic wr_sample(input int ch, input logic [17:0] v);
        @(negedge clk_in);
        wr_en_in   = 1'b1;
        wr_chan_in = 3'(ch);
        wr_data_in = v;
        @(negedge clk_in);
        wr_en_in = 1'b0;
        m_sample[ch] = v;
    endtask

    task automatic do_conv(input int os, input bit ramp, input int dup_at, input int abort_at,
                           input bit late_wr, input int lw_ch, input logic [17:0] lw_data);
        int        d;
        int        c;
        int        last;
        busy_exp_t e;
        d = (os >= 7) ? TC : (TC << os);
        os_in      = 3'(os);
        ramp_en_in = ramp;
        @(negedge clk_in);
        c = cyc;
        convst_in = 1'b1;
        e.start = c;
        e.dur   = (abort_at > 0) ? abort_at : d;
        e.cnt   = (abort_at > 0) ? m_cnt : m_cnt + 16'd1;
        e.ovr   = (abort_at > 0) ? 1'b0 : (m_ovr | (dup_at > 0));
        q_busy.push_back(e);
        last = (abort_at > 0) ? abort_at + 12 : d + 10;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk_in);
            if (i == 4) convst_in = 1'b0;
            if (i == 10) os_in = 3'($urandom_range(0, 7));
            if (dup_at > 0 && i == dup_at) convst_in = 1'b1;
            if (dup_at > 0 && i == dup_at + 4) convst_in = 1'b0;
            if (abort_at > 0 && i == abort_at) reset_in = 1'b1;
            if (abort_at > 0 && i == abort_at + 5) reset_in = 1'b0;
            if (late_wr && i == d + 2) begin
                wr_en_in   = 1'b1;
                wr_chan_in = 3'(lw_ch);
                wr_data_in = lw_data;
            end
            if (late_wr && i == d + 3) wr_en_in = 1'b0;
        end
        if (abort_at > 0) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = '0;
            m_ovr = 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) m_shadow[i] = ramp ? 18'(int'(m_cnt) + i) : m_sample[i];
            m_cnt = m_cnt + 16'd1;
            m_ovr = e.ovr;
        end
        if (late_wr) m_sample[lw_ch] = lw_data;
    endtask

    task automatic do_readout();
        frame_exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.a[(3-i)*WD +: WD] = m_shadow[i];
            e.b[(3-i)*WD +: WD] = m_shadow[i+4];
        end
        q_frame.push_back(e);
        @(negedge clk_in);
        n_cs_in = 1'b0;
        repeat (8) @(negedge clk_in);
        repeat (72) begin
            sclk_in = 1'b0;
            repeat (4) @(negedge clk_in);
            sclk_in = 1'b1;
            repeat (4) @(negedge clk_in);
        end
        repeat (2) @(negedge clk_in);
        n_cs_in = 1'b1;
        repeat (8) @(negedge clk_in);
    endtask

    task automatic reset_pin_pulse();
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (3) @(negedge clk_in);
        convst_in = 1'b1;
        repeat (4) @(negedge clk_in);
        convst_in = 1'b0;
        repeat (4) @(negedge clk_in);
        reset_in = 1'b0;
        repeat (6) @(negedge clk_in);
        for (int i = 0; i < 8; i++) m_shadow[i] = '0;
        m_ovr = 1'b0;
        check("reset_pin_overrun", 72'(overrun_out), 72'(0));
        check("reset_pin_busy", 72'(busy_out), 72'(0));
    endtask

    int sel;

    initial begin
        n_rst_in   = 1'b0;
        convst_in  = 1'b0;
        reset_in   = 1'b0;
        os_in      = 3'd0;
        sclk_in    = 1'b1;
        n_cs_in    = 1'b1;
        wr_en_in   = 1'b0;
        wr_chan_in = 3'd0;
        wr_data_in = '0;
        ramp_en_in = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_in);
        check("rst_busy", 72'(busy_out), 72'(0));
        check("rst_data_a", 72'(data_a_out), 72'(0));
        check("rst_data_b", 72'(data_b_out), 72'(0));
        check("rst_conv_cnt", 72'(conv_cnt_out), 72'(0));
        check("rst_overrun", 72'(overrun_out), 72'(0));
        n_rst_in = 1'b1;
        repeat (4) @(negedge clk_in);

        // Fixed patterns on ch0/ch4, random elsewhere
        wr_sample(0, 18'h2AAAA);
        wr_sample(4, 18'h15555);
        for (int ch = 1; ch < 8; ch++) if (ch != 4) wr_sample(ch, 18'($urandom));
        do_conv(0, 1'b0, 0, 0, 1'b0, 0, '0);
        do_readout();

        do_conv(2, 1'b0, 0, 0, 1'b0, 0, '0);
        do_conv(7, 1'b0, 0, 0, 1'b0, 0, '0);
        do_readout();

        // Second CONVST inside a conversion, then device RESET with a CONVST held under it
        do_conv(0, 1'b0, 50, 0, 1'b0, 0, '0);
        reset_pin_pulse();
        do_readout();

        // Readout spans a completing conversion that also sees a write on its snapshot cycle
        wr_sample(1, 18'($urandom));
        fork
            do_conv(0, 1'b0, 0, 0, 1'b1, 1, 18'($urandom));
            begin
                repeat (50) @(negedge clk_in);
                do_readout();
            end
        join
        do_readout();
        do_conv(1, 1'b0, 0, 0, 1'b0, 0, '0);
        do_readout();

        // Aborted conversions, one carrying an overrun that the abort must clear
        do_conv(0, 1'b0, 0, $urandom_range(20, 150), 1'b0, 0, '0);
        check("abort_overrun", 72'(overrun_out), 72'(0));
        do_conv(0, 1'b0, 10, 60, 1'b0, 0, '0);
        check("abort_dup_overrun", 72'(overrun_out), 72'(0));
        do_readout();

        for (int it = 0; it < 6; it++) begin
            wr_sample($urandom_range(0, 7), 18'($urandom));
            wr_sample($urandom_range(0, 7), 18'($urandom));
            sel = $urandom_range(0, 2);
            do_conv((sel == 2) ? 7 : sel, 1'($urandom_range(0, 1)), 0, 0, 1'b0, 0, '0);
            do_readout();
        end

        // Board reset in the middle of a readout
        @(negedge clk_in);
        n_cs_in = 1'b0;
        repeat (8) @(negedge clk_in);
        repeat (10) begin
            sclk_in = 1'b0;
            repeat (4) @(negedge clk_in);
            sclk_in = 1'b1;
            repeat (4) @(negedge clk_in);
        end
        n_rst_in = 1'b0;
        #1;
        check("nrst_data_a", 72'(data_a_out), 72'(0));
        check("nrst_data_b", 72'(data_b_out), 72'(0));
        check("nrst_busy", 72'(busy_out), 72'(0));
        check("nrst_conv_cnt", 72'(conv_cnt_out), 72'(0));
        check("nrst_overrun", 72'(overrun_out), 72'(0));
        n_cs_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_rst_in = 1'b1;
        model_reset();
        repeat (4) @(negedge clk_in);

        // Ramp from a fresh count: third snapshot carries 2..9
        repeat (3) do_conv(0, 1'b1, 0, 0, 1'b0, 0, '0);
        do_readout();

        repeat (20) @(negedge clk_in);
        check("busy_queue_drained", 72'(q_busy.size()), 72'(0));
        check("frame_queue_drained", 72'(q_frame.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
